// File: rtl/nvm_synapse_array_ctrl.sv
// Wishbone slave that fans one weight bit per macro out to a bank of NVM
// synapse macros (or gathers one bit back from each of them). The host is
// acked once every enabled macro has acked, or when the op times out.
// Handshake: a host request is stb & cyc & base-address hit & ~ack; a macro
// request is mac_stb_o[i], and mac_ack_i[i] only counts while it is high.
module nvm_synapse_array_ctrl #(
   parameter int          NUM_OF_MACRO   = 16,
   parameter logic [31:0] ADDR_BASE      = 32'h3000_0000,
   parameter logic [31:0] MACRO_ADDR     = 32'h3000_000C,
   parameter logic [7:0]  MEM_HIGH       = 8'hFF,
   parameter logic [7:0]  MEM_LOW        = 8'h00,
   parameter int          TIMEOUT_CYCLES = 256
) (
   input  logic                      wb_clk_i,
   input  logic                      wb_rst_i,
   input  logic                      wbs_stb_i,
   input  logic                      wbs_cyc_i,
   input  logic                      wbs_we_i,
   input  logic [3:0]                wbs_sel_i,
   input  logic [31:0]               wbs_dat_i,
   input  logic [31:0]               wbs_adr_i,
   output logic [31:0]               wbs_dat_o,
   output logic                      wbs_ack_o,
   output logic [NUM_OF_MACRO-1:0]   mac_stb_o,
   output logic                      mac_we_o,
   output logic [3:0]                mac_sel_o,
   output logic [31:0]               mac_adr_o,
   output logic [23:0]               mac_cmd_o,
   output logic [8*NUM_OF_MACRO-1:0] mac_wdat_o,
   input  logic [NUM_OF_MACRO-1:0]   mac_rdat_i,
   input  logic [NUM_OF_MACRO-1:0]   mac_ack_i
);

   localparam int N  = NUM_OF_MACRO;
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_ACK} state_t;

   state_t          state_q, state_d;
   logic [N-1:0]    mask_q, mask_d;
   logic            status_to_q, status_to_d;
   logic [N-1:0]    fail_q, fail_d;
   logic            we_l_q, we_l_d;
   logic [3:0]      sel_l_q, sel_l_d;
   logic [23:0]     cmd_l_q, cmd_l_d;
   logic [N-1:0]    wbit_l_q, wbit_l_d;
   logic [N-1:0]    mask_l_q, mask_l_d;
   logic [N-1:0]    seen_q, seen_d;
   logic [N-1:0]    rd_q, rd_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic            ack_q, ack_d;
   logic [31:0]     dat_q, dat_d;

   logic            in_issue;
   logic            req;
   logic [N-1:0]    ack_eff;
   logic [N-1:0]    seen_next;
   logic [N-1:0]    rd_next;
   logic [31:0]     mask_ext, fail_ext, rd_ext;

   assign in_issue  = (state_q == ST_ISSUE);
   assign req       = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:8] == ADDR_BASE[31:8]) & ~ack_q;
   assign ack_eff   = in_issue ? (mac_ack_i & mac_stb_o) : '0;
   assign seen_next = seen_q | ack_eff;
   assign rd_next   = (rd_q & ~ack_eff) | (ack_eff & mac_rdat_i);

   assign wbs_ack_o = ack_q;
   assign wbs_dat_o = dat_q;
   assign mac_adr_o = MACRO_ADDR;
   assign mac_stb_o = in_issue ? (mask_l_q & ~seen_q) : '0;
   assign mac_we_o  = in_issue & we_l_q;
   assign mac_sel_o = in_issue ? sel_l_q : 4'h0;
   assign mac_cmd_o = in_issue ? cmd_l_q : 24'h0;

   // Expand the latched weight bits into per-macro data bytes
   for (genvar i = 0; i < N; i++) begin : g_wdat
      assign mac_wdat_o[8*i +: 8] = in_issue ? (wbit_l_q[i] ? MEM_HIGH : MEM_LOW) : 8'h00;
   end

   // Zero-extend the N-bit registers onto the 32-bit read bus
   always_comb begin
      mask_ext = '0;
      fail_ext = '0;
      rd_ext   = '0;
      mask_ext[N-1:0] = mask_q;
      fail_ext[N-1:0] = fail_q;
      rd_ext[N-1:0]   = rd_next;
   end

   // Next-state logic: register decode in IDLE, macro ack collection in ISSUE
   always_comb begin
      state_d     = state_q;
      mask_d      = mask_q;
      status_to_d = status_to_q;
      fail_d      = fail_q;
      we_l_d      = we_l_q;
      sel_l_d     = sel_l_q;
      cmd_l_d     = cmd_l_q;
      wbit_l_d    = wbit_l_q;
      mask_l_d    = mask_l_q;
      seen_d      = seen_q;
      rd_d        = rd_q;
      timer_d     = timer_q;
      ack_d       = 1'b0;
      dat_d       = 32'h0;
      case (state_q)
         ST_IDLE: begin
            if (req) begin
               case (wbs_adr_i[7:0])
                  8'h00: begin
                     if (mask_q == '0) begin
                        state_d = ST_ACK;
                        ack_d   = 1'b1;
                        fail_d  = '0;
                     end else begin
                        state_d  = ST_ISSUE;
                        we_l_d   = wbs_we_i;
                        sel_l_d  = wbs_sel_i;
                        cmd_l_d  = wbs_dat_i[31:8];
                        wbit_l_d = wbs_dat_i[N-1:0];
                        mask_l_d = mask_q;
                        seen_d   = '0;
                        rd_d     = '0;
                        timer_d  = '0;
                     end
                  end
                  8'h04: begin
                     state_d = ST_ACK;
                     ack_d   = 1'b1;
                     if (wbs_we_i) mask_d = wbs_dat_i[N-1:0];
                     else          dat_d  = mask_ext;
                  end
                  8'h08: begin
                     state_d = ST_ACK;
                     ack_d   = 1'b1;
                     if (wbs_we_i) begin
                        if (wbs_dat_i[1]) status_to_d = 1'b0;
                     end else begin
                        dat_d = {30'h0, status_to_q, 1'b0};
                     end
                  end
                  8'h0C: begin
                     state_d = ST_ACK;
                     ack_d   = 1'b1;
                     if (!wbs_we_i) dat_d = fail_ext;
                  end
                  default: begin
                     state_d = ST_ACK;
                     ack_d   = 1'b1;
                  end
               endcase
            end
         end
         ST_ISSUE: begin
            if (!(wbs_stb_i && wbs_cyc_i)) begin
               // host abandoned the cycle: stop driving macros, no ack
               state_d = ST_IDLE;
            end else begin
               seen_d  = seen_next;
               rd_d    = rd_next;
               timer_d = timer_q + TW'(1);
               if (seen_next == mask_l_q) begin
                  // completion beats a coincident timeout
                  state_d = ST_ACK;
                  ack_d   = 1'b1;
                  fail_d  = '0;
                  dat_d   = we_l_q ? 32'h0 : rd_ext;
               end else if (timer_q == TIMER_MAX) begin
                  state_d     = ST_ACK;
                  ack_d       = 1'b1;
                  status_to_d = 1'b1;
                  fail_d      = mask_l_q & ~seen_next;
                  dat_d       = we_l_q ? 32'h0 : rd_ext;
               end
            end
         end
         ST_ACK: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // All state registers, synchronous active-high reset
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q     <= ST_IDLE;
         mask_q      <= '1;
         status_to_q <= 1'b0;
         fail_q      <= '0;
         we_l_q      <= 1'b0;
         sel_l_q     <= 4'h0;
         cmd_l_q     <= 24'h0;
         wbit_l_q    <= '0;
         mask_l_q    <= '0;
         seen_q      <= '0;
         rd_q        <= '0;
         timer_q     <= '0;
         ack_q       <= 1'b0;
         dat_q       <= 32'h0;
      end else begin
         state_q     <= state_d;
         mask_q      <= mask_d;
         status_to_q <= status_to_d;
         fail_q      <= fail_d;
         we_l_q      <= we_l_d;
         sel_l_q     <= sel_l_d;
         cmd_l_q     <= cmd_l_d;
         wbit_l_q    <= wbit_l_d;
         mask_l_q    <= mask_l_d;
         seen_q      <= seen_d;
         rd_q        <= rd_d;
         timer_q     <= timer_d;
         ack_q       <= ack_d;
         dat_q       <= dat_d;
      end
   end

endmodule

// File: tb/tb_nvm_synapse_array_ctrl.sv
// Directed bench for nvm_synapse_array_ctrl with a behavioural macro bank.
// Each macro acks on the d-th cycle its stb is high (d = delay[i]) unless it
// is marked as never acking. Expected read data is queued when a host access
// is driven and compared when wbs_ack_o arrives.
module tb_nvm_synapse_array_ctrl;

   localparam int N = 16;
   localparam logic [31:0] BASE = 32'h3000_0000;

   // clock / reset
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic          wbs_stb_i, wbs_cyc_i, wbs_we_i;
   logic [3:0]    wbs_sel_i;
   logic [31:0]   wbs_dat_i, wbs_adr_i;
   logic [31:0]   wbs_dat_o;
   logic          wbs_ack_o;
   logic [N-1:0]  mac_stb_o;
   logic          mac_we_o;
   logic [3:0]    mac_sel_o;
   logic [31:0]   mac_adr_o;
   logic [23:0]   mac_cmd_o;
   logic [8*N-1:0] mac_wdat_o;
   logic [N-1:0]  mac_rdat_i;
   logic [N-1:0]  mac_ack_i;

   nvm_synapse_array_ctrl dut (
      .wb_clk_i   (clk),
      .wb_rst_i   (rst),
      .wbs_stb_i  (wbs_stb_i),
      .wbs_cyc_i  (wbs_cyc_i),
      .wbs_we_i   (wbs_we_i),
      .wbs_sel_i  (wbs_sel_i),
      .wbs_dat_i  (wbs_dat_i),
      .wbs_adr_i  (wbs_adr_i),
      .wbs_dat_o  (wbs_dat_o),
      .wbs_ack_o  (wbs_ack_o),
      .mac_stb_o  (mac_stb_o),
      .mac_we_o   (mac_we_o),
      .mac_sel_o  (mac_sel_o),
      .mac_adr_o  (mac_adr_o),
      .mac_cmd_o  (mac_cmd_o),
      .mac_wdat_o (mac_wdat_o),
      .mac_rdat_i (mac_rdat_i),
      .mac_ack_i  (mac_ack_i)
   );

   // macro bank model
   int           delay [N];
   int           cnt   [N];
   logic [N-1:0] never;
   logic [N-1:0] rdat_pat;

   assign mac_rdat_i = rdat_pat;

   always @(posedge clk) begin
      for (int i = 0; i < N; i++) cnt[i] <= mac_stb_o[i] ? cnt[i] + 1 : 0;
   end

   always_comb begin
      mac_ack_i = '0;
      for (int i = 0; i < N; i++)
         mac_ack_i[i] = mac_stb_o[i] && !never[i] && (cnt[i] == delay[i] - 1);
   end

   // scoreboard
   logic [31:0] exp_q [$];
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic set_delays(input int d);
      for (int i = 0; i < N; i++) delay[i] = d;
   endtask

   // One host access; mask_m is the macro set expected to be driven (0 for none)
   task automatic wb_op(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [31:0] exp_dat, input int exp_lat,
                        input logic [N-1:0] mask_m, input string tag);
      logic [N-1:0]   seen_m;
      logic [8*N-1:0] exp_wdat;
      logic           got_ack;
      int             cyc_n;
      seen_m  = '0;
      got_ack = 1'b0;
      cyc_n   = 0;
      for (int i = 0; i < N; i++) exp_wdat[8*i +: 8] = dat[i] ? 8'hFF : 8'h00;
      @(negedge clk);
      wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = we;
      wbs_adr_i = adr;  wbs_dat_i = dat;  wbs_sel_i = 4'hF;
      exp_q.push_back(exp_dat);
      while (!got_ack && cyc_n < 400) begin
         @(negedge clk);
         cyc_n++;
         if (wbs_ack_o) begin
            got_ack = 1'b1;
         end else begin
            check({tag, "_stb"}, 128'(mac_stb_o), 128'(mask_m & ~seen_m));
            if (mask_m != '0) begin
               check({tag, "_wdat"}, 128'(mac_wdat_o), 128'(exp_wdat));
               check({tag, "_we"},   128'(mac_we_o),   128'(we));
               check({tag, "_sel"},  128'(mac_sel_o),  128'(4'hF));
               check({tag, "_cmd"},  128'(mac_cmd_o),  128'(dat[31:8]));
            end
            seen_m = seen_m | (mac_ack_i & mask_m & ~seen_m);
         end
      end
      check({tag, "_acked"}, 128'(got_ack), 128'(1'b1));
      if (got_ack) begin
         check({tag, "_dat"}, 128'(wbs_dat_o), 128'(exp_q.pop_front()));
         check({tag, "_lat"}, 128'(cyc_n), 128'(exp_lat));
      end else begin
         void'(exp_q.pop_front());
      end
      wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
      @(negedge clk);
      check({tag, "_ack_pulse"}, 128'(wbs_ack_o), 128'(1'b0));
      check({tag, "_dat_idle"},  128'(wbs_dat_o), 128'(32'h0));
      check({tag, "_stb_idle"},  128'(mac_stb_o), 128'(0));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ack"},  128'(wbs_ack_o),  128'(1'b0));
      check({tag, "_dat"},  128'(wbs_dat_o),  128'(32'h0));
      check({tag, "_stb"},  128'(mac_stb_o),  128'(0));
      check({tag, "_we"},   128'(mac_we_o),   128'(1'b0));
      check({tag, "_sel"},  128'(mac_sel_o),  128'(4'h0));
      check({tag, "_adr"},  128'(mac_adr_o),  128'(32'h3000_000C));
      check({tag, "_cmd"},  128'(mac_cmd_o),  128'(24'h0));
      check({tag, "_wdat"}, 128'(mac_wdat_o), 128'(0));
   endtask

   initial begin
      logic [N-1:0] rnd_rdat;
      int           max_d;
      // reset
      rst = 1'b1;
      wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
      wbs_sel_i = 4'h0; wbs_dat_i = 32'h0; wbs_adr_i = 32'h0;
      never = '0; rdat_pat = '0;
      set_delays(1);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_reset_outputs("reset");
      wb_op(1'b0, BASE + 32'h04, 32'h0, 32'h0000_FFFF, 1, '0, "rst_mask");
      wb_op(1'b0, BASE + 32'h08, 32'h0, 32'h0, 1, '0, "rst_status");
      wb_op(1'b0, BASE + 32'h0C, 32'h0, 32'h0, 1, '0, "rst_fail");

      // staggered write: macro i acks on cycle i+1, host ack one cycle after the 16th
      for (int i = 0; i < N; i++) delay[i] = i + 1;
      wb_op(1'b1, BASE, 32'h0000_A5A5, 32'h0, 17, 16'hFFFF, "stagger_wr");

      // read, every macro acks in the first issue cycle
      set_delays(1);
      rdat_pat = 16'h3C0F;
      wb_op(1'b0, BASE, 32'h0, 32'h0000_3C0F, 2, 16'hFFFF, "same_cyc_rd");

      // partial mask with random delays and read data
      wb_op(1'b1, BASE + 32'h04, 32'h0000_00F0, 32'h0, 1, '0, "mask_f0");
      max_d = 0;
      for (int i = 4; i < 8; i++) begin
         delay[i] = $urandom_range(1, 8);
         if (delay[i] > max_d) max_d = delay[i];
      end
      rnd_rdat = 16'($urandom_range(0, 16'hFFFF));
      rdat_pat = rnd_rdat;
      wb_op(1'b0, BASE, 32'h0, 32'(rnd_rdat & 16'h00F0), max_d + 1, 16'h00F0, "rand_rd");

      // timeout: macro1 never acks
      wb_op(1'b1, BASE + 32'h04, 32'h0000_0003, 32'h0, 1, '0, "mask_3");
      set_delays(1);
      never = 16'h0002;
      rdat_pat = 16'hFFFF;
      wb_op(1'b0, BASE, 32'h0, 32'h0000_0001, 257, 16'h0003, "timeout_rd");
      wb_op(1'b0, BASE + 32'h08, 32'h0, 32'h0000_0002, 1, '0, "to_status");
      wb_op(1'b0, BASE + 32'h0C, 32'h0, 32'h0000_0002, 1, '0, "to_fail");
      wb_op(1'b1, BASE + 32'h08, 32'h0000_0002, 32'h0, 1, '0, "w1c");
      wb_op(1'b0, BASE + 32'h08, 32'h0, 32'h0, 1, '0, "w1c_status");
      never = '0;

      // empty mask: immediate ack, no macro traffic, FAIL cleared
      wb_op(1'b1, BASE + 32'h04, 32'h0, 32'h0, 1, '0, "mask_0");
      wb_op(1'b1, BASE, 32'h0000_FFFF, 32'h0, 1, '0, "m0_wr");
      wb_op(1'b0, BASE, 32'h0, 32'h0, 1, '0, "m0_rd");
      wb_op(1'b0, BASE + 32'h0C, 32'h0, 32'h0, 1, '0, "m0_fail");

      // unmapped offset
      wb_op(1'b0, BASE + 32'h10, 32'h0, 32'h0, 1, '0, "unmapped_rd");
      wb_op(1'b1, BASE + 32'h10, 32'hFFFF_FFFF, 32'h0, 1, '0, "unmapped_wr");
      wb_op(1'b0, BASE + 32'h04, 32'h0, 32'h0, 1, '0, "mask_still_0");

      // foreign address is never acked
      @(negedge clk);
      wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 32'h3100_0000;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         check("foreign_noack", 128'(wbs_ack_o), 128'(1'b0));
      end
      wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;

      // abort: drop cyc in ISSUE
      wb_op(1'b1, BASE + 32'h04, 32'h0000_FFFF, 32'h0, 1, '0, "mask_ffff");
      never = '1;
      @(negedge clk);
      wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b1;
      wbs_adr_i = BASE; wbs_dat_i = 32'h0000_00FF;
      repeat (3) @(negedge clk);
      check("abort_busy_stb", 128'(mac_stb_o), 128'(16'hFFFF));
      wbs_cyc_i = 1'b0;
      @(negedge clk);
      check("abort_stb", 128'(mac_stb_o), 128'(0));
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("abort_noack", 128'(wbs_ack_o), 128'(1'b0));
      end
      wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
      never = '0;
      wb_op(1'b0, BASE + 32'h08, 32'h0, 32'h0, 1, '0, "abort_status");
      wb_op(1'b0, BASE + 32'h0C, 32'h0, 32'h0, 1, '0, "abort_fail");

      // reset during ISSUE restores every reset value
      wb_op(1'b1, BASE + 32'h04, 32'h0000_0F0F, 32'h0, 1, '0, "mask_0f0f");
      never = '1;
      @(negedge clk);
      wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b1;
      wbs_adr_i = BASE; wbs_dat_i = 32'hFFFF_FFFF;
      repeat (3) @(negedge clk);
      check("rstop_busy_stb", 128'(mac_stb_o), 128'(16'h0F0F));
      check("rstop_busy_cmd", 128'(mac_cmd_o), 128'(24'hFF_FFFF));
      rst = 1'b1;
      @(negedge clk);
      check_reset_outputs("rstop");
      wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
      rst = 1'b0;
      never = '0;
      @(negedge clk);
      check_reset_outputs("rstop_after");
      wb_op(1'b0, BASE + 32'h04, 32'h0, 32'h0000_FFFF, 1, '0, "rstop_mask");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
